alu_acc: RTL and testbench
==========================

# alu_acc

Arithmetic/logic unit with the accumulator, buffer and multiplier registers (ACC, BR, MR) for the microprogrammed accumulator CPU. It sits directly downstream of the control unit: it decodes the registered 32-bit `control_signal` word, takes operands from the MBR, and returns the results and `flags[7:0]`. `flags[0]` drives the JMPGEZ branch in the control unit. Multiply is multi-cycle (radix-2 Booth); every other operation completes in a single cycle.

## Interface
- `DATA_W`, default 16: width of ACC, BR, MR and MBR data.
- `MPY_ITER`, default `DATA_W`: number of Booth iterations.

Ports:
- `clk`  input  1  clock.
- `rst`  input  1  reset, asynchronous, active-low.
- `control_signal`  input  32  control unit output word, one bit per micro-operation.
- `mbr_in`  input  `DATA_W`  current MBR contents.
- `acc_out`  output  `DATA_W`  ACC; consumed by `acc2mbr`.
- `mr_out`  output  `DATA_W`  MR (high product word); consumed by `alu2mbr`/`mr2mbr`.
- `flags`  output  8  {0, multi_op_err, busy_err, busy, V, C, Z, N}.
- `busy`  output  1  multiply in progress (same as `flags[4]`).

## Operation
- Decoded bits:
  - `mbr2br` (bit 6): BR<=mbr_in.
  - `mbr2acc` (bit 10): ACC<=mbr_in.
  - `acc_clear` (bit 21): ACC<=0.
  - Operation bits 22..31: add, sub, and, or, not, lsl, lsr, mpy, asl, asr.
- All other bits are ignored.
- Operations:
  - ADD: ACC<=ACC+BR. C=carry out; V=signed overflow.
  - SUB: ACC<=ACC-BR. C=1 when no borrow (ACC>=BR unsigned); V=signed overflow.
  - AND: ACC<=ACC&BR. OR: ACC<=ACC|BR. NOT: ACC<=~BR. For AND/OR/NOT, C and V are cleared.
  - LSL/ASL: ACC shifted left by 1. C=bit shifted out. V=0 for LSL; for ASL, V=1 when the sign bit changes.
  - LSR: ACC shifted right by 1 with zero fill. ASR: ACC shifted right by 1 with sign fill. For both, C=bit shifted out and V=0.
  - MPY: signed ACC×BR producing a 2·DATA_W result in {MR,ACC}.
- Flag updates:
  - N and Z are updated on every op, on `mbr2acc` and on `acc_clear`; they are computed from the new ACC.
  - For MPY, N and Z are computed from the full 32-bit product.
- Priority within one cycle:
  - A valid op bit has priority over `mbr2acc`, which has priority over `acc_clear`.
  - `mbr2br` in the same cycle as an op: the op uses the old BR.
- More than one op bit set: the lowest set index executes, and `multi_op_err` (`flags[6]`) is set.
- Any op bit sampled while `busy` is high: the op is ignored, `busy_err` (`flags[5]`) is set, and `mbr2acc`/`acc_clear` are also ignored. `mbr2br` is still honoured.
- Both error flags are sticky and are cleared only by `rst`.
- MPY state machine:
  - States: IDLE -> RUN -> IDLE.
  - Start: on the edge where MPY is sampled in IDLE, the block latches multiplicand=BR and multiplier=ACC, sets MR<=0 and the Booth extra bit<=0, sets counter<=MPY_ITER, and sets busy<=1.
  - RUN: each cycle performs one Booth step (add or subtract the multiplicand on MR, then arithmetic right shift of {MR,ACC,q-1}) and decrements the counter.
  - Exit: when the counter reaches 0, the state returns to IDLE, busy<=0 and the flags update. C=0. V=1 when the product does not fit in DATA_W signed.
- `acc_out`/`mr_out` show partial products while busy. Consumers must wait for `busy` to be low.

## Timing
- Reset (async, `rst`=0): ACC, BR and MR are 0; flags=8'h02 (Z=1); busy=0; state=IDLE; counter=0.
- Single-cycle ops: the result and flags are visible right after the edge that samples the control bit (latency 1).
- MPY: busy is high for exactly MPY_ITER cycles after the start edge. The result and flags are valid, and busy is low, after start edge + MPY_ITER (16 cycles by default).
- Reset asserted mid-multiply aborts the multiply immediately; all registers return to their reset values.
- Outputs are registered directly; there is no combinational path from `control_signal` to any output.

## Structure
- Shared package `cpu_pkg` holds:
  - control-bit index constants (MBR2BR=6, MBR2ACC=10, ACC_CLEAR=21, ADDITION=22 … ARITH_SHR=31);
  - flag index constants (FLAG_N=0 … FLAG_MULTI=6);
  - `DATA_W`.
  The control unit's bit definitions are migrated to this package.
- One sub-module, `booth_mpy_seq`: it owns the Booth step, the counter and the busy flag, and hands back {MR,ACC} plus done. `alu_acc` keeps decode, single-cycle ops, flags and the error registers.

## Test plan
- ADD: ACC=0x7FFF, BR=0x0001 -> ACC=0x8000, N=1, Z=0, C=0, V=1.
- SUB: ACC=5, BR=7 -> ACC=0xFFFE, N=1, C=0, V=0. Then a JMPGEZ check on `flags[0]`=1.
- LOAD microsequence: `acc_clear|mbr2br` with mbr_in=0x1234, then ADD -> ACC=0x1234, Z=0.
- MPY: ACC=0xFFFD (-3), BR=7 -> busy high for 16 cycles, then MR=0xFFFF, ACC=0xFFEB, N=1, V=0. Also 0x4000×4 -> MR=0x0001, ACC=0x0000, V=1.
- Shifts:
  - ASR 0x8002 -> 0xC001, C=0.
  - LSR 0x0003 -> 0x0001, C=1.
  - ASL 0x4000 -> 0x8000, V=1.
  - LSL 0x8000 -> 0x0000, C=1, Z=1.
- Errors and reset:
  - ADD issued at cycle 5 of an MPY -> ignored, product still correct, `flags[5]`=1.
  - `rst` low at cycle 8 of an MPY -> all registers 0, busy=0, flags=8'h02.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: control-word bit positions, flag positions, data width.
// Latency: n/a (package only).
// Backpressure: n/a; the control unit and alu_acc both import this so bit positions live in one place.
package cpu_pkg;

  localparam int DATA_W = 16;

  // Control word bit positions (one bit per micro-operation).
  localparam int MBR2BR      = 6;
  localparam int MBR2ACC     = 10;
  localparam int ACC_CLEAR   = 21;
  localparam int ADDITION    = 22;
  localparam int SUBTRACT    = 23;
  localparam int AND_OP      = 24;
  localparam int OR_OP       = 25;
  localparam int NOT_OP      = 26;
  localparam int SHIFT_LEFT  = 27;
  localparam int SHIFT_RIGHT = 28;
  localparam int MULTIPLY    = 29;
  localparam int ARITH_SHL   = 30;
  localparam int ARITH_SHR   = 31;

  localparam int OP_NUM = ARITH_SHR - ADDITION + 1;

  // Flag bit positions.
  localparam int FLAG_N        = 0;
  localparam int FLAG_Z        = 1;
  localparam int FLAG_C        = 2;
  localparam int FLAG_V        = 3;
  localparam int FLAG_BUSY     = 4;
  localparam int FLAG_BUSY_ERR = 5;
  localparam int FLAG_MULTI    = 6;

  // Operation index relative to ADDITION; order must follow the control bits.
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT,
    OP_LSL, OP_LSR, OP_MPY, OP_ASL, OP_ASR
  } op_e;

  typedef enum logic {MPY_IDLE, MPY_RUN} mpy_state_e;

  // Lowest set op bit wins when several are asserted.
  function automatic op_e lowest_op(input logic [OP_NUM-1:0] bits);
    op_e sel;
    sel = OP_ADD;
    for (int i = OP_NUM - 1; i >= 0; i--) begin
      if (bits[i]) sel = op_e'(i[3:0]);
    end
    return sel;
  endfunction

  // True when more than one op bit is set.
  function automatic logic multi_hot(input logic [OP_NUM-1:0] bits);
    return (bits & (bits - {{(OP_NUM-1){1'b0}}, 1'b1})) != '0;
  endfunction

endpackage

// File: rtl/booth_mpy_seq.sv
// Radix-2 Booth sequencer: owns multiplicand, q-1 bit, iteration counter and busy; the product lives in the caller's {MR,ACC}.
// Latency: busy for MPY_ITER cycles after start; done pulses on the final step edge.
// Backpressure: none; start is ignored while busy (caller flags the misuse).
// Ports: clk, rst (async active-low), start, mcand_in (BR), hi_in/lo_in (current MR/ACC),
//        hi_next/lo_next (product after this cycle's step), step (apply next), done, busy.
module booth_mpy_seq #(
  parameter int DATA_W   = 16,
  parameter int MPY_ITER = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] mcand_in,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  output logic [DATA_W-1:0] hi_next,
  output logic [DATA_W-1:0] lo_next,
  output logic              step,
  output logic              done,
  output logic              busy
);
  import cpu_pkg::*;

  localparam int CNT_W = $clog2(MPY_ITER + 1);

  mpy_state_e        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              q_1;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W:0]   hi_ext, mc_ext, sum;

  // One guard bit on the partial sum keeps add/sub of the most negative
  // multiplicand from overflowing before the arithmetic right shift.
  always_comb begin
    hi_ext = {hi_in[DATA_W-1], hi_in};
    mc_ext = {mcand[DATA_W-1], mcand};
    case ({lo_in[0], q_1})
      2'b01:   sum = hi_ext + mc_ext;
      2'b10:   sum = hi_ext - mc_ext;
      default: sum = hi_ext;
    endcase
    hi_next = sum[DATA_W:1];
    lo_next = {sum[0], lo_in[DATA_W-1:1]};
    step    = (state == MPY_RUN);
    done    = step && (cnt == CNT_W'(1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MPY_IDLE: if (start) state_nxt = MPY_RUN;
      MPY_RUN:  if (cnt == CNT_W'(1)) state_nxt = MPY_IDLE;
      default:  state_nxt = MPY_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= MPY_IDLE;
      cnt   <= '0;
      q_1   <= 1'b0;
      mcand <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == MPY_IDLE) begin
        if (start) begin
          mcand <= mcand_in;
          q_1   <= 1'b0;
          cnt   <= CNT_W'(MPY_ITER);
          busy  <= 1'b1;
        end
      end else begin
        q_1 <= lo_in[0];
        cnt <= cnt - CNT_W'(1);
        if (done) busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_acc.sv
// ALU with ACC/BR/MR: decodes the control word, runs single-cycle ops, multiply via booth_mpy_seq, keeps flags.
// Latency: 1 cycle for single-cycle ops and loads; MPY_ITER cycles after the start edge for multiply.
// Backpressure: busy high during multiply; ops issued then are dropped and latch the sticky busy_err.
// Ports: clk, rst (async active-low), control_signal[31:0], mbr_in, acc_out, mr_out,
//        flags = {0, multi_op_err, busy_err, busy, V, C, Z, N}, busy.
module alu_acc #(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int MPY_ITER = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       control_signal,
  input  logic [DATA_W-1:0] mbr_in,
  output logic [DATA_W-1:0] acc_out,
  output logic [DATA_W-1:0] mr_out,
  output logic [7:0]        flags,
  output logic              busy
);
  import cpu_pkg::*;

  logic [DATA_W-1:0] acc, br, mr;
  logic              n_flag, z_flag, c_flag, v_flag;
  logic              busy_err, multi_err;

  logic [OP_NUM-1:0] op_bits;
  logic              any_op, multi;
  op_e               sel;

  logic [DATA_W-1:0] res;
  logic              c_nxt, v_nxt;
  logic [DATA_W:0]   wide;

  logic              mpy_start, mpy_step, mpy_done;
  logic [DATA_W-1:0] prod_hi, prod_lo;

  logic              unused_ctrl;
  assign unused_ctrl = ^{control_signal[ACC_CLEAR-1:MBR2ACC+1],
                         control_signal[MBR2ACC-1:MBR2BR+1],
                         control_signal[MBR2BR-1:0]};

  assign op_bits   = control_signal[ARITH_SHR:ADDITION];
  assign any_op    = |op_bits;
  assign multi     = multi_hot(op_bits);
  assign sel       = lowest_op(op_bits);
  assign mpy_start = any_op && !busy && (sel == OP_MPY);

  always_comb begin
    res   = acc;
    c_nxt = c_flag;
    v_nxt = v_flag;
    wide  = '0;
    case (sel)
      OP_ADD: begin
        wide  = {1'b0, acc} + {1'b0, br};
        res   = wide[DATA_W-1:0];
        c_nxt = wide[DATA_W];
        v_nxt = (acc[DATA_W-1] == br[DATA_W-1]) && (res[DATA_W-1] != acc[DATA_W-1]);
      end
      OP_SUB: begin
        wide  = {1'b0, acc} - {1'b0, br};
        res   = wide[DATA_W-1:0];
        c_nxt = ~wide[DATA_W];  // carry = not borrow
        v_nxt = (acc[DATA_W-1] != br[DATA_W-1]) && (res[DATA_W-1] != acc[DATA_W-1]);
      end
      OP_AND: begin res = acc & br; c_nxt = 1'b0; v_nxt = 1'b0; end
      OP_OR:  begin res = acc | br; c_nxt = 1'b0; v_nxt = 1'b0; end
      OP_NOT: begin res = ~br;      c_nxt = 1'b0; v_nxt = 1'b0; end
      OP_LSL: begin
        res   = {acc[DATA_W-2:0], 1'b0};
        c_nxt = acc[DATA_W-1];
        v_nxt = 1'b0;
      end
      OP_ASL: begin
        res   = {acc[DATA_W-2:0], 1'b0};
        c_nxt = acc[DATA_W-1];
        v_nxt = acc[DATA_W-1] ^ acc[DATA_W-2];
      end
      OP_LSR: begin
        res   = {1'b0, acc[DATA_W-1:1]};
        c_nxt = acc[0];
        v_nxt = 1'b0;
      end
      OP_ASR: begin
        res   = {acc[DATA_W-1], acc[DATA_W-1:1]};
        c_nxt = acc[0];
        v_nxt = 1'b0;
      end
      default: ;  // MPY: ACC untouched on the start edge
    endcase
  end

  booth_mpy_seq #(.DATA_W(DATA_W), .MPY_ITER(MPY_ITER)) u_mpy (
    .clk      (clk),
    .rst      (rst),
    .start    (mpy_start),
    .mcand_in (br),
    .hi_in    (mr),
    .lo_in    (acc),
    .hi_next  (prod_hi),
    .lo_next  (prod_lo),
    .step     (mpy_step),
    .done     (mpy_done),
    .busy     (busy)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      br        <= '0;
      mr        <= '0;
      n_flag    <= 1'b0;
      z_flag    <= 1'b1;
      c_flag    <= 1'b0;
      v_flag    <= 1'b0;
      busy_err  <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      // BR load is always honoured; an op in the same cycle still sees the old BR.
      if (control_signal[MBR2BR]) br <= mbr_in;

      if (busy) begin
        // ACC/MR hold the running product, so no other writer may touch them.
        if (any_op) busy_err <= 1'b1;
        if (mpy_step) begin
          acc <= prod_lo;
          mr  <= prod_hi;
        end
        if (mpy_done) begin
          n_flag <= prod_hi[DATA_W-1];
          z_flag <= ({prod_hi, prod_lo} == '0);
          c_flag <= 1'b0;
          v_flag <= (prod_hi != {DATA_W{prod_lo[DATA_W-1]}});
        end
      end else if (any_op) begin
        if (multi) multi_err <= 1'b1;
        if (sel == OP_MPY) begin
          mr <= '0;
        end else begin
          acc    <= res;
          n_flag <= res[DATA_W-1];
          z_flag <= (res == '0);
          c_flag <= c_nxt;
          v_flag <= v_nxt;
        end
      end else if (control_signal[MBR2ACC]) begin
        acc    <= mbr_in;
        n_flag <= mbr_in[DATA_W-1];
        z_flag <= (mbr_in == '0);
      end else if (control_signal[ACC_CLEAR]) begin
        acc    <= '0;
        n_flag <= 1'b0;
        z_flag <= 1'b1;
      end
    end
  end

  assign acc_out = acc;
  assign mr_out  = mr;
  assign flags   = {1'b0, multi_err, busy_err, busy, v_flag, c_flag, z_flag, n_flag};

endmodule

// File: tb/tb_alu_acc.sv
// Directed bench for alu_acc: loads operands through the MBR control bits and checks results/flags.
// Latency: checks 1 time unit after each sampling edge.
// Backpressure: multiply completion waits are bounded by a cycle budget.
module tb_alu_acc;
  import cpu_pkg::*;

  localparam logic [31:0] C_BR   = 32'h1 << MBR2BR;
  localparam logic [31:0] C_ACC  = 32'h1 << MBR2ACC;
  localparam logic [31:0] C_CLR  = 32'h1 << ACC_CLEAR;
  localparam logic [31:0] C_ADD  = 32'h1 << ADDITION;
  localparam logic [31:0] C_SUB  = 32'h1 << SUBTRACT;
  localparam logic [31:0] C_LSL  = 32'h1 << SHIFT_LEFT;
  localparam logic [31:0] C_LSR  = 32'h1 << SHIFT_RIGHT;
  localparam logic [31:0] C_MPY  = 32'h1 << MULTIPLY;
  localparam logic [31:0] C_ASL  = 32'h1 << ARITH_SHL;
  localparam logic [31:0] C_ASR  = 32'h1 << ARITH_SHR;

  logic        clk;
  logic        rst;
  logic [31:0] control_signal;
  logic [15:0] mbr_in;
  logic [15:0] acc_out;
  logic [15:0] mr_out;
  logic [7:0]  flags;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int ncyc;

  alu_acc dut (
    .clk            (clk),
    .rst            (rst),
    .control_signal (control_signal),
    .mbr_in         (mbr_in),
    .acc_out        (acc_out),
    .mr_out         (mr_out),
    .flags          (flags),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one control word for exactly one sampling edge.
  task automatic step(input logic [31:0] c, input logic [15:0] m);
    @(negedge clk);
    control_signal = c;
    mbr_in = m;
    @(posedge clk);
    #1;
    control_signal = '0;
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] b);
    step(C_ACC, a);
    step(C_BR, b);
  endtask

  // Count edges until busy drops, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    rst = 1'b0;
    control_signal = '0;
    mbr_in = '0;
    #12;
    chk("rst_acc",   acc_out, 16'h0000);
    chk("rst_mr",    mr_out,  16'h0000);
    chk("rst_flags", flags,   8'h02);
    chk("rst_busy",  busy,    1'b0);
    @(negedge clk);
    rst = 1'b1;

    // ADD with signed overflow
    load(16'h7FFF, 16'h0001);
    step(C_ADD, 16'h0);
    chk("add_acc",   acc_out, 16'h8000);
    chk("add_flags", flags,   8'h09);

    // SUB with borrow; flags[0] (N) is what JMPGEZ looks at
    load(16'h0005, 16'h0007);
    step(C_SUB, 16'h0);
    chk("sub_acc",    acc_out,  16'hFFFE);
    chk("sub_flags",  flags,    8'h01);
    chk("sub_jmpgez", flags[0], 1'b1);

    // LOAD microsequence
    step(C_CLR | C_BR, 16'h1234);
    chk("clr_acc",   acc_out, 16'h0000);
    chk("clr_flags", flags,   8'h02);
    step(C_ADD, 16'h0);
    chk("load_acc",   acc_out, 16'h1234);
    chk("load_flags", flags,   8'h00);

    // MPY -3 * 7
    load(16'hFFFD, 16'h0007);
    step(C_MPY, 16'h0);
    chk("mpy1_busy", busy, 1'b1);
    wait_idle(ncyc);
    chk("mpy1_cycles", ncyc,    16);
    chk("mpy1_mr",     mr_out,  16'hFFFF);
    chk("mpy1_acc",    acc_out, 16'hFFEB);
    chk("mpy1_flags",  flags,   8'h01);

    // MPY 0x4000 * 4 overflows DATA_W
    load(16'h4000, 16'h0004);
    step(C_MPY, 16'h0);
    wait_idle(ncyc);
    chk("mpy2_cycles", ncyc,    16);
    chk("mpy2_mr",     mr_out,  16'h0001);
    chk("mpy2_acc",    acc_out, 16'h0000);
    chk("mpy2_flags",  flags,   8'h08);

    // Shifts
    step(C_ACC, 16'h8002);
    step(C_ASR, 16'h0);
    chk("asr_acc",   acc_out, 16'hC001);
    chk("asr_flags", flags,   8'h01);
    step(C_ACC, 16'h0003);
    step(C_LSR, 16'h0);
    chk("lsr_acc",   acc_out, 16'h0001);
    chk("lsr_flags", flags,   8'h04);
    step(C_ACC, 16'h4000);
    step(C_ASL, 16'h0);
    chk("asl_acc",   acc_out, 16'h8000);
    chk("asl_flags", flags,   8'h09);
    step(C_ACC, 16'h8000);
    step(C_LSL, 16'h0);
    chk("lsl_acc",   acc_out, 16'h0000);
    chk("lsl_flags", flags,   8'h06);

    // Multiple op bits: ADD (lowest) wins, sticky multi_op_err
    load(16'h0003, 16'h0002);
    step(C_ADD | C_SUB, 16'h0);
    chk("multi_acc",   acc_out, 16'h0005);
    chk("multi_flags", flags,   8'h40);
    // op beats mbr2acc
    step(C_ADD | C_ACC, 16'h1000);
    chk("prio_acc", acc_out, 16'h0007);
    // op uses old BR when mbr2br is in the same cycle
    step(C_ADD | C_BR, 16'h0100);
    chk("oldbr_acc", acc_out, 16'h0009);
    step(C_ADD, 16'h0);
    chk("newbr_acc",   acc_out, 16'h0109);
    chk("newbr_flags", flags,   8'h40);

    // ADD during multiply is dropped and sets busy_err
    load(16'hFFFD, 16'h0007);
    step(C_MPY, 16'h0);
    repeat (4) @(posedge clk);
    step(C_ADD | C_ACC, 16'h5555);
    wait_idle(ncyc);
    chk("berr_busy",  busy,    1'b0);
    chk("berr_mr",    mr_out,  16'hFFFF);
    chk("berr_acc",   acc_out, 16'hFFEB);
    chk("berr_flags", flags,   8'h61);

    // Reset mid-multiply
    load(16'h0123, 16'h0456);
    step(C_MPY, 16'h0);
    repeat (7) @(posedge clk);
    #3;
    chk("mid_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("arst_acc",   acc_out, 16'h0000);
    chk("arst_mr",    mr_out,  16'h0000);
    chk("arst_busy",  busy,    1'b0);
    chk("arst_flags", flags,   8'h02);
    @(negedge clk);
    rst = 1'b1;
    step(C_ADD, 16'h0);
    chk("post_rst_acc",   acc_out, 16'h0000);
    chk("post_rst_flags", flags,   8'h02);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
